// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and request-error helper for the SRAM slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    // Anything other than a single 32-bit-or-narrower INCR beat inside the SRAM window.
    function automatic logic req_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst, input logic addr_hi);
        return (len != 8'd0) || (size > 3'd2) || (burst != BURST_INCR) || addr_hi;
    endfunction

endpackage

// File: rtl/sram_port_arb.sv
// Two-requester round-robin arbiter for the single SRAM port; combinational grant.
module sram_port_arb
    import axi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_rd,
    input  logic req_wr,
    output logic gnt_rd,
    output logic gnt_wr
);

    grant_t last_grant;

    // Only contended cycles move the pointer; a lone requester never shifts priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GRANT_WR;
        end else if (req_rd && req_wr) begin
            last_grant <= (last_grant == GRANT_WR) ? GRANT_RD : GRANT_WR;
        end
    end

    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (req_rd && req_wr) begin
            if (last_grant == GRANT_WR) gnt_rd = 1'b1;
            else                        gnt_wr = 1'b1;
        end else begin
            gnt_rd = req_rd;
            gnt_wr = req_wr;
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave backed by one synchronous single-port SRAM.
// Define AXI_SLV_ERR_EN to answer malformed or out-of-range requests with SLVERR.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned MEM_AW = 16
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,

    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic [ID_W-1:0]   rd_id, wr_id;
    logic [MEM_AW-1:0] rd_addr, wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              aw_held, w_held, wr_err;
    logic              ar_hs, aw_hs, w_hs;
    logic              ar_err, aw_err, wr_err_now;
    logic              have_aw, have_w;
    logic              req_rd, req_wr, gnt_rd, gnt_wr;
    logic              unused_bits;

`ifdef AXI_SLV_ERR_EN
    assign ar_err      = req_err(arlen, arsize, arburst, |araddr[31:MEM_AW+2]);
    assign aw_err      = req_err(awlen, awsize, awburst, |awaddr[31:MEM_AW+2]);
    assign unused_bits = ^{araddr[1:0], awaddr[1:0], wid, wlast};
`else
    assign ar_err      = 1'b0;
    assign aw_err      = 1'b0;
    assign unused_bits = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0],
                           arlen, arsize, arburst, awlen, awsize, awburst, wid, wlast};
`endif

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // ---------------- read channel ----------------
    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) rd_next = ar_err ? R_RESP : R_REQ;
            end
            R_REQ:   if (gnt_rd) rd_next = R_WAIT;
            R_WAIT:  rd_next = R_RESP;
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            rd_id    <= '0;
            rd_addr  <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rd_id   <= arid;
                rd_addr <= araddr[MEM_AW+1:2];
                rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                if (ar_err) rdata <= '0;
            end
            if (rd_state == R_WAIT) rdata <= ram_rdata;
        end
    end

    assign rid   = rd_id;
    assign rlast = rvalid;

    // ---------------- write channel ----------------
    assign have_aw    = aw_held || aw_hs;
    assign have_w     = w_held || w_hs;
    assign wr_err_now = aw_held ? wr_err : aw_err;

    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = !aw_held;
                wready  = !w_held;
                if (have_aw && have_w) wr_next = wr_err_now ? W_RESP : W_REQ;
            end
            W_REQ:   if (gnt_wr) wr_next = W_RESP;
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_err   <= 1'b0;
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_held <= 1'b1;
                wr_id   <= awid;
                wr_addr <= awaddr[MEM_AW+1:2];
                wr_err  <= aw_err;
                bresp   <= aw_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            // Capture flags drop as IDLE is left, overriding any same-cycle capture above.
            if ((wr_state == W_IDLE) && (wr_next != W_IDLE)) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    assign bid = wr_id;

    // ---------------- shared SRAM port ----------------
    assign req_rd = (rd_state == R_REQ);
    assign req_wr = (wr_state == W_REQ);

    sram_port_arb u_arb (
        .clk    (aclk),
        .rst_n  (aresetn),
        .req_rd (req_rd),
        .req_wr (req_wr),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

    assign ram_en    = gnt_rd || gnt_wr;
    assign ram_we    = gnt_wr ? wr_strb : '0;
    assign ram_addr  = gnt_wr ? wr_addr : rd_addr;
    assign ram_wdata = wr_data;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table, hand-written corner sequences,
// and randomized traffic compared against a word-level memory model.
module tb_axi_sram_slave;

    localparam int ID_W   = 4;
    localparam int MEM_AW = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ID_W-1:0]   arid = '0, awid = '0, wid = '0;
    logic [31:0]       araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]        arlen = '0, awlen = '0;
    logic [2:0]        arsize = 3'd2, awsize = 3'd2;
    logic [1:0]        arburst = 2'b01, awburst = 2'b01;
    logic              arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b1;
    logic              rready = 1'b0, bready = 1'b0;
    logic [3:0]        wstrb = '0;
    logic              arready, awready, wready, rvalid, rlast, bvalid;
    logic [ID_W-1:0]   rid, bid;
    logic [31:0]       rdata;
    logic [1:0]        rresp, bresp;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_val(input int unsigned a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Synchronous SRAM: preloaded on the first edge (held in reset), 1-cycle read latency.
    logic [31:0] sram [0:(1<<MEM_AW)-1];
    logic        sram_init = 1'b0;
    always @(posedge aclk) begin
        if (!sram_init) begin
            for (int i = 0; i < (1 << MEM_AW); i++) sram[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= sram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int               ram_en_cnt = 0;
    logic [MEM_AW-1:0] last_en_addr = '0;
    logic [3:0]        last_en_we = '0;
    always @(negedge aclk) begin
        if (ram_en) begin
            ram_en_cnt   = ram_en_cnt + 1;
            last_en_addr = ram_addr;
            last_en_we   = ram_we;
        end
    end

    // Reference: word-addressed memory, byte lanes merged by a strobe mask.
    logic [31:0] ref_mem [int unsigned];
    function automatic logic [31:0] ref_read(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction
    function automatic void ref_write(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[w] = (ref_read(w) & ~m) | (d & m);
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no DUT handshake within cycle budget", name);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input int stall, output logic [31:0] data, output logic [3:0] id_o,
                            output logic [1:0] resp, output logic last, output int lat,
                            output logic ok);
        logic acc;
        int   cyc;
        ok = 1'b0; data = '0; id_o = '0; resp = '0; last = 1'b0; lat = -1;
        araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b0;
        acc = 1'b0; cyc = 0;
        while (!acc && cyc < 20) begin
            @(negedge aclk); acc = arready;
            @(posedge aclk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!acc) begin timed_out("ar_handshake"); return; end
        cyc = 1;
        @(negedge aclk);
        while (!rvalid && cyc < 20) begin
            @(posedge aclk); #1;
            cyc++;
            @(negedge aclk);
        end
        if (!rvalid) begin timed_out("r_valid"); @(posedge aclk); #1; return; end
        lat = cyc; data = rdata; id_o = rid; resp = rresp; last = rlast;
        for (int s = 0; s < stall; s++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            check("r_hold_valid", {31'b0, rvalid}, 32'd1);
            check("r_hold_data", rdata, data);
            check("r_hold_id", {28'b0, rid}, {28'b0, id_o});
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        ok = 1'b1;
    endtask

    // w_lead > 0: W leads AW by that many cycles; < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int bdelay,
                             output logic [3:0] id_o, output logic [1:0] resp, output logic ok);
        logic aw_done, w_done, aw_acc, w_acc, got;
        int   cyc, aw_start, w_start;
        ok = 1'b0; id_o = '0; resp = '0;
        awaddr = addr; awid = id; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        wdata = data; wstrb = strb; wid = id; wlast = 1'b1;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            @(negedge aclk);
            if (w_done && !aw_done)  check("wready_after_w", {31'b0, wready}, 32'd0);
            if (aw_done && !w_done)  check("awready_after_aw", {31'b0, awready}, 32'd0);
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            @(posedge aclk); #1;
            aw_done = aw_done || aw_acc;
            w_done  = w_done || w_acc;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin timed_out("aw_w_handshake"); return; end
        bready = (bdelay == 0);
        got = 1'b0; cyc = 0;
        while (!got && cyc < 30) begin
            @(negedge aclk);
            if (bvalid && bready) begin got = 1'b1; id_o = bid; resp = bresp; end
            @(posedge aclk); #1;
            cyc++;
            if (cyc >= bdelay) bready = 1'b1;
        end
        bready = 1'b0;
        if (!got) begin timed_out("b_handshake"); return; end
        ok = 1'b1;
    endtask

    task automatic drain(output logic [31:0] rd, output logic [3:0] id_o,
                         output logic got_r, output logic got_b);
        got_r = 1'b0; got_b = 1'b0; rd = '0; id_o = '0;
        rready = 1'b1; bready = 1'b1;
        for (int c = 0; c < 20 && !(got_r && got_b); c++) begin
            @(negedge aclk);
            if (rvalid) begin got_r = 1'b1; rd = rdata; id_o = rid; end
            if (bvalid) got_b = 1'b1;
            @(posedge aclk); #1;
        end
        rready = 1'b0; bready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [31:0] pre;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lead;
        logic [15:0] ram_a;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] d, exp_r;
    logic [3:0]  id_o;
    logic [1:0]  resp;
    logic        last, ok, got_r, got_b;
    int          lat, en0;

    initial begin
        vecs[0] = '{32'h0000_0010, 4'd1,  32'h0000_0000, 32'hDEAD_BEEF, 4'b1111,  0, 16'h0004, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0020, 4'd2,  32'h1122_3344, 32'h0000_AB00, 4'b0010,  2, 16'h0008, 32'h1122_AB44};
        vecs[2] = '{32'h0000_0024, 4'd3,  32'hAABB_CCDD, 32'h1234_5678, 4'b0000, -1, 16'h0009, 32'hAABB_CCDD};
        vecs[3] = '{32'h0000_002B, 4'd0,  32'hFFFF_FFFF, 32'h0000_0000, 4'b0101,  0, 16'h000A, 32'hFF00_FF00};
        vecs[4] = '{32'h0003_FFFC, 4'd15, 32'h0102_0304, 32'hA0B0_C0D0, 4'b1000,  1, 16'hFFFF, 32'hA002_0304};

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_readies", {29'b0, arready, awready, wready}, 32'h7);
        check("rst_valids", {29'b0, rvalid, bvalid, rlast}, 32'h0);
        check("rst_ram", {27'b0, ram_en, ram_we}, 32'h0);
        check("rst_ids_resp", {20'b0, rid, bid, rresp, bresp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // First tie after reset: read wins, write one cycle later
        araddr = 32'h44; arid = 4'd2; arlen = 8'd0;
        awaddr = 32'h40; awid = 4'd3; awlen = 8'd0; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        check("tie1_ready", {29'b0, arready, awready, wready}, 32'h7);
        @(posedge aclk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check("tie1_c1_port", {11'b0, ram_en, ram_we, ram_addr}, {11'b0, 1'b1, 4'h0, 16'd17});
        @(posedge aclk); #1;
        @(negedge aclk);
        check("tie1_c2_port", {11'b0, ram_en, ram_we, ram_addr}, {11'b0, 1'b1, 4'hF, 16'd16});
        @(posedge aclk); #1;
        exp_r = ref_read(17);
        ref_write(16, 32'h0BAD_F00D, 4'hF);
        drain(d, id_o, got_r, got_b);
        check("tie1_done", {30'b0, got_r, got_b}, 32'h3);
        check("tie1_rdata", d, exp_r);
        check("tie1_rid", {28'b0, id_o}, 32'd2);

        // Second tie: write wins; same word so the read sees the new data
        araddr = 32'h40; arid = 4'd4;
        awaddr = 32'h40; awid = 4'd5; wdata = 32'hCAFE_1234; wstrb = 4'b0011;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check("tie2_c1_port", {11'b0, ram_en, ram_we, ram_addr}, {11'b0, 1'b1, 4'b0011, 16'd16});
        @(posedge aclk); #1;
        @(negedge aclk);
        check("tie2_c2_port", {11'b0, ram_en, ram_we, ram_addr}, {11'b0, 1'b1, 4'h0, 16'd16});
        @(posedge aclk); #1;
        ref_write(16, 32'hCAFE_1234, 4'b0011);
        drain(d, id_o, got_r, got_b);
        check("tie2_done", {30'b0, got_r, got_b}, 32'h3);
        check("tie2_rdata", d, ref_read(16));

        // Vector table: preload, partial write, read back
        for (int i = 0; i < 5; i++) begin
            axi_write(vecs[i].addr, vecs[i].id, vecs[i].pre, 4'hF, 0, 0, id_o, resp, ok);
            ref_write(vecs[i].ram_a, vecs[i].pre, 4'hF);
            axi_write(vecs[i].addr, vecs[i].id, vecs[i].wdata, vecs[i].strb, vecs[i].lead, 1,
                      id_o, resp, ok);
            ref_write(vecs[i].ram_a, vecs[i].wdata, vecs[i].strb);
            check("vec_bid", {28'b0, id_o}, {28'b0, vecs[i].id});
            check("vec_bresp", {30'b0, resp}, 32'd0);
            check("vec_ram_addr", {16'b0, last_en_addr}, {16'b0, vecs[i].ram_a});
            check("vec_ram_we", {28'b0, last_en_we}, {28'b0, vecs[i].strb});
            axi_read(vecs[i].addr, vecs[i].id, 8'd0, 0, d, id_o, resp, last, lat, ok);
            check("vec_rdata", d, vecs[i].exp);
            check("vec_rid_resp_last", {25'b0, id_o, resp, last}, {25'b0, vecs[i].id, 2'b00, 1'b1});
            check("vec_latency", lat, 3);
        end

        // Backpressure: R held while a write completes
        rready = 1'b0;
        araddr = 32'h10; arid = 4'd6; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        lat = 0;
        @(negedge aclk);
        while (!rvalid && lat < 20) begin @(posedge aclk); #1; lat++; @(negedge aclk); end
        check("bp_rvalid", {31'b0, rvalid}, 32'd1);
        @(posedge aclk); #1;
        axi_write(32'h80, 4'd5, 32'h5555_AAAA, 4'hF, 0, 0, id_o, resp, ok);
        ref_write(32, 32'h5555_AAAA, 4'hF);
        check("bp_write_done", {30'b0, ok, id_o == 4'd5}, 32'h3);
        for (int s = 0; s < 3; s++) begin
            @(negedge aclk);
            check("bp_r_stable", {27'b0, rvalid, rid}, {27'b0, 1'b1, 4'd6});
            check("bp_rdata_stable", rdata, ref_read(4));
            @(posedge aclk); #1;
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        check("bp_r_released", {31'b0, rvalid}, 32'd0);
        @(posedge aclk); #1;

        // Reset while holding a read response
        araddr = 32'h20; arid = 4'd7; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        lat = 0;
        @(negedge aclk);
        while (!rvalid && lat < 20) begin @(posedge aclk); #1; lat++; @(negedge aclk); end
        check("rst_mid_rvalid_before", {31'b0, rvalid}, 32'd1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("rst_mid_after", {30'b0, rvalid, arready}, 32'h1);
        aresetn = 1'b1;
        rready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            check("rst_mid_no_stale", {30'b0, rvalid, bvalid}, 32'h0);
        end
        rready = 1'b0;
        @(posedge aclk); #1;

        // Malformed / out-of-range requests
        en0 = ram_en_cnt;
        axi_read(32'h10, 4'd1, 8'd3, 0, d, id_o, resp, last, lat, ok);
`ifdef AXI_SLV_ERR_EN
        check("err_len_rresp", {30'b0, resp}, 32'h2);
        check("err_len_rdata", d, 32'h0);
        check("err_len_no_ram", ram_en_cnt - en0, 0);
        en0 = ram_en_cnt;
        axi_write(32'h0004_0008, 4'd2, 32'h7777_7777, 4'hF, 0, 0, id_o, resp, ok);
        check("err_oob_bresp", {29'b0, ok, resp}, 32'h6);
        check("err_oob_no_ram", ram_en_cnt - en0, 0);
`else
        check("len3_rresp", {30'b0, resp}, 32'h0);
        check("len3_rdata", d, ref_read(4));
        check("len3_ram_used", ram_en_cnt - en0, 1);
        axi_write(32'h0004_0008, 4'd2, 32'h7777_7777, 4'hF, 0, 0, id_o, resp, ok);
        ref_write(2, 32'h7777_7777, 4'hF);
        check("trunc_bresp", {29'b0, ok, resp}, 32'h4);
        axi_read(32'h0000_0008, 4'd2, 8'd0, 0, d, id_o, resp, last, lat, ok);
        check("trunc_rdata", d, ref_read(2));
`endif

        // Randomized traffic against the word model
        for (int i = 0; i < 60; i++) begin
            int unsigned w;
            logic [31:0] a, dat;
            logic [3:0]  id, st;
            w   = $urandom_range(0, 31);
            a   = (w << 2) | $urandom_range(0, 3);
            id  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                dat = $urandom;
                st  = 4'($urandom_range(0, 15));
                axi_write(a, id, dat, st, int'($urandom_range(0, 4)) - 2,
                          int'($urandom_range(0, 3)), id_o, resp, ok);
                ref_write(w, dat, st);
                check("rnd_b", {25'b0, ok, id_o, resp}, {25'b0, 1'b1, id, 2'b00});
            end else begin
                axi_read(a, id, 8'd0, int'($urandom_range(0, 3)), d, id_o, resp, last, lat, ok);
                check("rnd_rdata", d, ref_read(w));
                check("rnd_r", {24'b0, ok, id_o, resp, last}, {24'b0, 1'b1, id, 2'b00, 1'b1});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
